// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and
// baud-rate helpers used to size timing parameters.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitDone,
        StGap
    } arb_state_e;

    // Clocks per UART bit, rounded to nearest.
    function automatic int unsigned clk_per_bit(input int unsigned clk_rate,
                                                input int unsigned baud_rate);
        return (clk_rate + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// The parent registers the result.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] index,
    output logic            any
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt   = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdxW'((32'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                index     = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NUM_REQ byte
// sources, with a stall timeout and an idle gap between packets.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned CLK_RATE       = 25_000_000,
    parameter int unsigned BAUD_RATE      = 115_200,
    parameter int unsigned GAP_CYCLES     = clk_per_bit(CLK_RATE, BAUD_RATE),
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    output logic [NUM_REQ-1:0]             grant,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           abort
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IdW-1:0]     grant_id_q, grant_id_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               last_q, last_d;
    logic [TmoW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IdW-1:0]       arb_idx;
    logic                 arb_any;
    logic                 g_valid;
    logic                 g_last;
    logic [DATA_BITS-1:0] g_data;
    logic                 timed_out;
    logic                 gap_done;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .req  (req_valid),
        .ptr  (rr_ptr_q),
        .gnt  (arb_gnt),
        .index(arb_idx),
        .any  (arb_any)
    );

    // One-hot mux of the owner's byte stream.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_valid = g_valid | req_valid[i];
                g_last  = g_last | req_last[i];
                g_data  = g_data | req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign timed_out = (32'(tmo_cnt_q) == TIMEOUT_CYCLES);
    assign gap_done  = (32'(gap_cnt_q) + 32'd1 >= GAP_CYCLES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            last_q     <= 1'b0;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            last_q     <= last_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        last_d     = last_q;
        tmo_cnt_d  = tmo_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            StIdle: begin
                if (arb_any) begin
                    grant_d    = arb_gnt;
                    grant_id_d = arb_idx;
                    rr_ptr_d   = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
                    tmo_cnt_d  = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (abort) begin
                    grant_d   = '0;
                    tmo_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end else if (tx_start) begin
                    last_d    = g_last;
                    tmo_cnt_d = '0;
                    state_d   = StWaitDone;
                end else if (!g_valid) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (tx_done) begin
                    if (last_q) begin
                        grant_d   = '0;
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StGap: begin
                if (gap_done) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The abort cycle takes priority over a late byte: no handshake is offered.
    always_comb begin
        req_ready = '0;
        tx_start  = 1'b0;
        tx_data   = '0;
        abort     = 1'b0;
        if (state_q == StSend) begin
            if (timed_out) begin
                abort = 1'b1;
            end else begin
                req_ready = tx_busy ? '0 : grant_q;
                tx_start  = g_valid & ~tx_busy;
                tx_data   = g_data;
            end
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requester byte queues and a uart_tx
// stand-in drive the DUT; an owner/timestamp reference model predicts outputs.
module tb_uart_tx_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned GAP = 4;
    localparam int unsigned TMO = 16;
    localparam int          GapLen = (GAP == 0) ? 1 : int'(GAP);

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_last, req_ready, grant;
    logic [N*DW-1:0] req_data;
    logic            tx_start, tx_busy, tx_done, abort;
    logic [DW-1:0]   tx_data;
    logic [1:0]      grant_id;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .DATA_BITS     (DW),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .grant    (grant),
        .grant_id (grant_id),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    // Requester sources: {last, data} per entry.
    logic [8:0]   q [N][$];
    logic [N-1:0] en;
    int           cyc;
    int           uart_left, hold_busy;
    bit           rnd_mode;

    // Reference model state.
    int m_owner, m_id, m_ptr, m_stall, m_idle_from;
    bit m_waiting, m_last;

    // Observed DUT events.
    int           g_cyc[$];
    logic [N-1:0] g_val[$];
    int           s_cyc[$];
    logic [DW-1:0] s_byte[$];
    int           a_cyc[$];
    int           d_cyc[$];
    logic [N-1:0] prev_grant;

    int unsigned n_checks, n_pass;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    endtask

    task automatic drive_inputs();
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                e = q[i][0];
                req_valid[i] = en[i];
                req_data[i*DW +: DW] = e[7:0];
                req_last[i] = e[8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = DW'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
        if (uart_left > 0) begin
            tx_busy = 1'b1;
            tx_done = (uart_left == 1);
            uart_left--;
        end else if (hold_busy > 0) begin
            tx_busy = 1'b1;
            tx_done = 1'b0;
            hold_busy--;
        end else begin
            tx_busy = 1'b0;
            tx_done = 1'b0;
        end
    endtask

    task automatic model_cycle();
        logic [N-1:0] exp_grant, exp_ready;
        logic         exp_start, exp_abort;
        logic [8:0]   head, e;
        int           o, w, c;
        o = m_owner;
        exp_grant = '0;
        exp_ready = '0;
        exp_start = 1'b0;
        exp_abort = 1'b0;
        head = '0;
        if (o >= 0) begin
            exp_grant[o] = 1'b1;
            if (q[o].size() > 0) head = q[o][0];
            if (!m_waiting) begin
                if (m_stall == int'(TMO)) exp_abort = 1'b1;
                else if (!tx_busy) begin
                    exp_ready[o] = 1'b1;
                    exp_start = req_valid[o];
                end
            end
        end
        check_eq("grant", 32'(grant), 32'(exp_grant));
        check_eq("grant_id", 32'(grant_id), 32'(m_id));
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("tx_start", 32'(tx_start), 32'(exp_start));
        check_eq("abort", 32'(abort), 32'(exp_abort));
        if (exp_start && tx_start) check_eq("tx_data", 32'(tx_data), 32'(head[7:0]));

        if (prev_grant == '0 && grant != '0) begin
            g_cyc.push_back(cyc);
            g_val.push_back(grant);
        end
        prev_grant = grant;
        if (tx_start) begin
            s_cyc.push_back(cyc);
            s_byte.push_back(tx_data);
        end
        if (abort) a_cyc.push_back(cyc);
        if (tx_done) d_cyc.push_back(cyc);

        if (o < 0) begin
            if (cyc >= m_idle_from && req_valid != '0) begin
                w = -1;
                for (int k = 0; k < int'(N); k++) begin
                    c = (m_ptr + k) % int'(N);
                    if (w < 0 && req_valid[c]) w = c;
                end
                m_owner = w;
                m_id = w;
                m_ptr = (w + 1) % int'(N);
                m_stall = 0;
                m_waiting = 0;
            end
        end else if (!m_waiting) begin
            if (exp_abort) begin
                while (q[o].size() > 0) begin
                    e = q[o].pop_front();
                    if (e[8]) break;
                end
                m_owner = -1;
                m_idle_from = cyc + GapLen + 1;
            end else if (exp_start) begin
                e = q[o].pop_front();
                m_last = e[8];
                m_waiting = 1;
                m_stall = 0;
                uart_left = $urandom_range(2, 6);
                if (rnd_mode && $urandom_range(0, 7) == 0) hold_busy = $urandom_range(1, 6);
            end else if (!req_valid[o]) begin
                m_stall++;
            end
        end else if (tx_done) begin
            if (m_last) begin
                m_owner = -1;
                m_idle_from = cyc + GapLen + 1;
            end else begin
                m_waiting = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic clear_logs();
        g_cyc.delete();
        g_val.delete();
        s_cyc.delete();
        s_byte.delete();
        a_cyc.delete();
        d_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        en = '1;
        uart_left = 0;
        hold_busy = 0;
        drive_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_owner = -1;
        m_id = 0;
        m_ptr = 0;
        m_stall = 0;
        m_idle_from = 0;
        m_waiting = 0;
        m_last = 0;
        prev_grant = '0;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (q[i].size() > 0) return 0;
        return 1;
    endfunction

    task automatic run_until_quiet(input int max_cycles);
        bit quiet;
        quiet = 0;
        for (int k = 0; k < max_cycles && !quiet; k++) begin
            step();
            quiet = (m_owner < 0) && (cyc >= m_idle_from) && queues_empty();
        end
        if (!quiet) check_eq("quiet_timeout", 32'(quiet), 32'd1);
    endtask

    task automatic push_pkt(input int r, input int len);
        logic lastb;
        for (int b = 0; b < len; b++) begin
            lastb = (b == len - 1);
            q[r].push_back({lastb, 8'($urandom)});
        end
    endtask

    initial begin
        int r;
        n_checks = 0;
        n_pass = 0;
        cyc = 0;
        rnd_mode = 0;
        en = '1;
        uart_left = 0;
        hold_busy = 0;
        reset_n = 1'b1;
        drive_inputs();
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_abort", 32'(abort), 32'd0);
        do_reset();

        // Single two-byte packet from requester 1.
        clear_logs();
        q[1].push_back({1'b0, 8'hA5});
        q[1].push_back({1'b1, 8'h3C});
        run_until_quiet(200);
        check_eq("t1_nbytes", 32'(s_byte.size()), 32'd2);
        check_eq("t1_byte0", 32'(s_byte[0]), 32'hA5);
        check_eq("t1_byte1", 32'(s_byte[1]), 32'h3C);
        check_eq("t1_grant", 32'(g_val[0]), 32'b0010);
        check_eq("t1_aborts", 32'(a_cyc.size()), 32'd0);

        // All four valid after reset, one-byte packets.
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) push_pkt(i, 1);
        push_pkt(0, 1);
        run_until_quiet(400);
        for (int k = 0; k < 5; k++) check_eq("t2_order", 32'(g_val[k]), 32'(1 << (k % 4)));
        for (int k = 1; k < 5; k++)
            check_eq("t2_gap", 32'(g_cyc[k] - d_cyc[k-1]), GAP + 2);

        // Requester 2 stalls mid-packet until the timeout.
        clear_logs();
        q[2].push_back({1'b0, 8'h11});
        q[2].push_back({1'b1, 8'h22});
        for (int k = 0; k < 100 && s_byte.size() < 1; k++) step();
        check_eq("t3_first_byte", 32'(s_byte.size()), 32'd1);
        en[2] = 1'b0;
        for (int k = 0; k < 100 && a_cyc.size() < 1; k++) step();
        check_eq("t3_abort_seen", 32'(a_cyc.size()), 32'd1);
        check_eq("t3_abort_time", 32'(a_cyc[0] - d_cyc[0]), TMO + 1);
        en[2] = 1'b1;
        run_until_quiet(100);
        check_eq("t3_nbytes", 32'(s_byte.size()), 32'd1);
        clear_logs();
        for (int i = 0; i < N; i++) push_pkt(i, 1);
        run_until_quiet(400);
        check_eq("t3_next_owner", 32'(g_val[0]), 32'b1000);

        // uart_tx holds busy for 10 cycles after the first byte's done.
        clear_logs();
        q[0].push_back({1'b0, 8'h5A});
        q[0].push_back({1'b1, 8'hC3});
        for (int k = 0; k < 100 && s_byte.size() < 1; k++) step();
        hold_busy = 10;
        run_until_quiet(200);
        check_eq("t4_start_delay", 32'(s_cyc[1] - d_cyc[0]), 32'd11);
        check_eq("t4_byte1", 32'(s_byte[1]), 32'hC3);
        check_eq("t4_aborts", 32'(a_cyc.size()), 32'd0);

        // Reset while waiting for tx_done.
        clear_logs();
        push_pkt(1, 2);
        for (int k = 0; k < 100 && !(m_owner >= 0 && m_waiting); k++) step();
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_grant", 32'(grant), 32'd0);
        check_eq("t5_grant_id", 32'(grant_id), 32'd0);
        check_eq("t5_ready", 32'(req_ready), 32'd0);
        check_eq("t5_tx_start", 32'(tx_start), 32'd0);
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) push_pkt(i, 1);
        run_until_quiet(400);
        check_eq("t5_first_owner", 32'(g_val[0]), 32'b0001);

        // No preemption: requester 0 arrives during requester 3's packet.
        clear_logs();
        push_pkt(3, 3);
        for (int k = 0; k < 50 && g_val.size() < 1; k++) step();
        push_pkt(0, 1);
        run_until_quiet(300);
        check_eq("t6_first", 32'(g_val[0]), 32'b1000);
        check_eq("t6_second", 32'(g_val[1]), 32'b0001);
        check_eq("t6_gap", 32'(g_cyc[1] - d_cyc[2]), GAP + 2);

        // Random traffic with stalls and slow uart_tx release.
        rnd_mode = 1;
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom_range(0, N - 1);
                if (q[r].size() < 6) push_pkt(r, $urandom_range(1, 3));
            end
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
            step();
        end
        en = '1;
        rnd_mode = 0;
        run_until_quiet(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
